wasca_audio_i2s_tx: RTL and testbench

Slave-mode I2S transmitter with stereo sample FIFO, driving the cartridge audio DAC data pin from samples written by the system interconnect. Sits between the Avalon-MM interconnect, written by the NIOS core or the A-bus slave's audio path, and the external codec. The codec supplies BCLK and LRCK; this block only drives DACDAT. Runs entirely in the 116 MHz system clock domain and oversamples the codec clocks.

---
 rtl/wasca_audio_i2s_tx_if.sv | 22 ++
 rtl/wasca_audio_i2s_tx.sv | 175 +++++++++++++++++
 tb/tb_wasca_audio_i2s_tx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wasca_audio_i2s_tx_if.sv
// Avalon-MM style write port for the I2S transmitter sample FIFO.
// The master drives stereo frames and the write strobe; the slave
// answers with waitrequest while its FIFO is full.
interface wasca_audio_i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [2*SAMPLE_WIDTH-1:0] s_writedata;
  logic                      s_write;
  logic                      s_waitrequest;

  modport master (
    output s_writedata,
    output s_write,
    input  s_waitrequest
  );

  modport slave (
    input  s_writedata,
    input  s_write,
    output s_waitrequest
  );
endinterface

// File: rtl/wasca_audio_i2s_tx.sv
// Slave-mode I2S transmitter for the cartridge audio DAC.
// Stereo frames are written into a FIFO from the system interconnect and
// shifted out on DACDAT, timed by the codec's BCLK/LRCK which are
// oversampled in the system clock domain.
// Optional build macro WASCA_I2S_HOLD_LAST_EN: when defined, an underrun
// retransmits the last frame popped from the FIFO instead of silence.
module wasca_audio_i2s_tx #(
  parameter int FIFO_DEPTH   = 16,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  wasca_audio_i2s_tx_if.slave         s_bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  input  logic                        bclk,
  input  logic                        daclrck,
  output logic                        dacdat
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 2 * SAMPLE_WIDTH;
  localparam int CW = $clog2(SAMPLE_WIDTH + 2);

  localparam logic [CW-1:0] CNT_LAST   = CW'(SAMPLE_WIDTH);
  localparam logic [CW-1:0] CNT_SAT    = CW'(SAMPLE_WIDTH + 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } state_t;

  // Codec clock synchronizers and edge detect
  logic bclk_meta, bclk_sync, bclk_d;
  logic lrck_meta, lrck_sync, lrck_prev;
  logic bfall, lrck_fall, lrck_rise;

  // FIFO storage and bookkeeping
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [FW-1:0] rd_data;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_next;
  logic          wr_en, pop_en, fifo_empty;

  // Serializer
  state_t                  state;
  logic [CW-1:0]           bit_cnt;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic [SAMPLE_WIDTH-1:0] hold_reg;
  logic                    load_pending;
  logic [FW-1:0]           fallback;

`ifdef WASCA_I2S_HOLD_LAST_EN
  logic [FW-1:0] last_frame;
  assign fallback = last_frame;
`else
  assign fallback = '0;
`endif

  assign bfall     = bclk_d & ~bclk_sync;
  assign lrck_fall = bfall & lrck_prev & ~lrck_sync;
  assign lrck_rise = bfall & ~lrck_prev & lrck_sync;

  assign fifo_empty = (fifo_level == '0);
  assign wr_en      = s_bus.s_write & ~s_bus.s_waitrequest;
  assign pop_en     = lrck_fall & ~fifo_empty;
  assign level_next = fifo_level + LW'(wr_en) - LW'(pop_en);

  // Bring BCLK/LRCK into the clk domain; LRCK is only sampled on BCLK falls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_meta <= 1'b0;
      bclk_sync <= 1'b0;
      bclk_d    <= 1'b0;
      lrck_meta <= 1'b0;
      lrck_sync <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_meta <= bclk;
      bclk_sync <= bclk_meta;
      bclk_d    <= bclk_sync;
      lrck_meta <= daclrck;
      lrck_sync <= lrck_meta;
      if (bfall) begin
        lrck_prev <= lrck_sync;
      end
    end
  end

  // Frame storage with a registered read of the head entry (RAM friendly)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_bus.s_writedata;
    end
    rd_data <= mem[rd_ptr];
  end

  // FIFO pointers, level and the registered full indication
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_level          <= '0;
      s_bus.s_waitrequest <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_level          <= level_next;
      s_bus.s_waitrequest <= (level_next == LEVEL_FULL);
    end
  end

  // Slot FSM and serializer; the LRCK fall that leaves SYNC starts the first frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SYNC;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      hold_reg     <= '0;
      load_pending <= 1'b0;
      underrun     <= 1'b0;
      dacdat       <= 1'b0;
`ifdef WASCA_I2S_HOLD_LAST_EN
      last_frame   <= '0;
`endif
    end else begin
      underrun     <= 1'b0;
      load_pending <= 1'b0;
      if (lrck_fall) begin
        state        <= LEFT;
        bit_cnt      <= '0;
        dacdat       <= 1'b0;
        load_pending <= 1'b1;
        underrun     <= fifo_empty;
      end else if (bfall && state != SYNC) begin
        if (lrck_rise) begin
          state     <= RIGHT;
          shift_reg <= hold_reg;
          bit_cnt   <= '0;
          dacdat    <= 1'b0;
        end else begin
          if (bit_cnt != CNT_SAT) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (bit_cnt < CNT_LAST) begin
            dacdat    <= shift_reg[SAMPLE_WIDTH-1];
            shift_reg <= shift_reg << 1;
          end else begin
            dacdat <= 1'b0;
          end
        end
      end
      if (load_pending) begin
        if (underrun) begin
          shift_reg <= fallback[FW-1:SAMPLE_WIDTH];
          hold_reg  <= fallback[SAMPLE_WIDTH-1:0];
        end else begin
          shift_reg <= rd_data[FW-1:SAMPLE_WIDTH];
          hold_reg  <= rd_data[SAMPLE_WIDTH-1:0];
`ifdef WASCA_I2S_HOLD_LAST_EN
          last_frame <= rd_data;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_wasca_audio_i2s_tx.sv
// Testbench for wasca_audio_i2s_tx: acts as the codec (BCLK = 64 x fs,
// 10 system clocks per BCLK) and as the interconnect master, and checks
// the DAC stream, FIFO level, waitrequest and underrun pulses against a
// frame-level model of the transmitter.
module tb_wasca_audio_i2s_tx;

  localparam int DEPTH = 16;
  localparam int SW    = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       bclk = 1'b1;
  logic       daclrck = 1'b1;
  logic [4:0] fifo_level;
  logic       underrun;
  logic       dacdat;

  wasca_audio_i2s_tx_if #(.SAMPLE_WIDTH(SW)) bus ();

  wasca_audio_i2s_tx #(
    .FIFO_DEPTH  (DEPTH),
    .SAMPLE_WIDTH(SW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_bus     (bus),
    .fifo_level(fifo_level),
    .underrun  (underrun),
    .bclk      (bclk),
    .daclrck   (daclrck),
    .dacdat    (dacdat)
  );

  always #4 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: queued frames, slot position since the last LRCK edge, frame history
  logic [31:0] model_q[$];
  bit          synced;
  logic        prev_lr;
  int          slot_bit;
  logic [15:0] slot_word;
  logic [15:0] right_word;
  logic [31:0] last_frame;
  int          ur_count;
  bit          pending;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    synced     = 1'b0;
    prev_lr    = 1'b0;
    slot_bit   = 0;
    slot_word  = '0;
    right_word = '0;
    last_frame = '0;
  endtask

  // One system clock; also completes a stalled write once the DUT takes it
  task automatic tick();
    bit will_accept;
    will_accept = pending && (bus.s_waitrequest === 1'b0);
    @(negedge clk);
    if (underrun === 1'b1) ur_count++;
    if (will_accept) begin
      checkOutput("stalled_write_needs_room", 32'(model_q.size() < DEPTH), 32'd1);
      model_q.push_back(bus.s_writedata);
      bus.s_write = 1'b0;
      pending = 1'b0;
    end
  endtask

  task automatic write_frame(input logic [31:0] d);
    checkOutput("waitrequest_pre_write", bus.s_waitrequest, model_q.size() == DEPTH);
    bus.s_writedata = d;
    bus.s_write = 1'b1;
    if (model_q.size() < DEPTH) begin
      @(negedge clk);
      bus.s_write = 1'b0;
      model_q.push_back(d);
    end else begin
      pending = 1'b1;
    end
  endtask

  // One BCLK period: fall (LRCK may change), codec samples DACDAT on the rise
  task automatic bclk_cycle(input logic lr, input bit co_write, input logic [31:0] co_data,
                            input bit reset_here);
    logic [31:0] cur;
    logic        exp_bit;
    bit          exp_ur;
    ur_count = 0;
    exp_ur   = 1'b0;
    bclk     = 1'b0;
    daclrck  = lr;
    if (prev_lr === 1'b1 && lr === 1'b0) begin
      synced = 1'b1;
      exp_ur = (model_q.size() == 0);
      if (model_q.size() == 0) begin
`ifdef WASCA_I2S_HOLD_LAST_EN
        cur = last_frame;
`else
        cur = '0;
`endif
      end else begin
        cur = model_q.pop_front();
        last_frame = cur;
      end
      slot_word  = cur[31:16];
      right_word = cur[15:0];
      slot_bit   = 0;
    end else if (prev_lr === 1'b0 && lr === 1'b1 && synced) begin
      slot_word = right_word;
      slot_bit  = 0;
    end else if (slot_bit < SW + 1) begin
      slot_bit++;
    end
    prev_lr = lr;
    exp_bit = (synced && slot_bit >= 1 && slot_bit <= SW) ? slot_word[SW - slot_bit] : 1'b0;

    tick();
    tick();
    if (co_write) begin
      bus.s_writedata = co_data;
      bus.s_write = 1'b1;
    end
    tick();
    if (co_write) begin
      bus.s_write = 1'b0;
      model_q.push_back(co_data);
    end
    tick();
    tick();
    bclk = 1'b1;
    checkOutput("dacdat", dacdat, exp_bit);
    checkOutput("fifo_level", fifo_level, model_q.size());
    checkOutput("waitrequest", bus.s_waitrequest, model_q.size() == DEPTH);
    if (reset_here) begin
      reset_n = 1'b0;
      #1;
      checkOutput("reset_async_dacdat", dacdat, 1'b0);
      checkOutput("reset_async_level", fifo_level, 5'd0);
      checkOutput("reset_async_waitrequest", bus.s_waitrequest, 1'b0);
      model_reset();
      tick();
      tick();
      tick();
      reset_n = 1'b1;
    end
    repeat (5) tick();
    checkOutput("underrun_pulses", ur_count, exp_ur ? 1 : 0);
  endtask

  // One stereo frame: LRCK low for the left 32 BCLKs, high for the right 32
  task automatic applyStimulus(input bit co_write, input logic [31:0] co_data, input int reset_at);
    for (int k = 0; k < 64; k++) begin
      bclk_cycle((k < 32) ? 1'b0 : 1'b1, co_write && (k == 0), co_data, k == reset_at);
    end
  endtask

  initial begin
    int n;
    int guard;
    bus.s_write = 1'b0;
    bus.s_writedata = '0;
    pending = 1'b0;
    model_reset();

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    checkOutput("rst_dacdat", dacdat, 1'b0);
    checkOutput("rst_waitrequest", bus.s_waitrequest, 1'b0);
    checkOutput("rst_level", fifo_level, 5'd0);
    checkOutput("rst_underrun", underrun, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] codec clocks running before first LRCK fall");
    for (int i = 0; i < 8; i++) bclk_cycle(1'b1, 1'b0, '0, 1'b0);

    $display("[TB] single frame A5A5_3C3C");
    write_frame(32'hA5A5_3C3C);
    applyStimulus(1'b0, '0, -1);

    $display("[TB] frame then underrun");
    write_frame(32'h1234_5678);
    applyStimulus(1'b0, '0, -1);
    applyStimulus(1'b0, '0, -1);

    $display("[TB] fill FIFO with codec clocks stopped");
    for (int i = 0; i < DEPTH + 1; i++) write_frame($urandom);
    checkOutput("full_level", fifo_level, DEPTH);
    applyStimulus(1'b0, '0, -1);
    checkOutput("refilled_level", fifo_level, DEPTH);
    repeat (DEPTH - 1) applyStimulus(1'b0, '0, -1);

    $display("[TB] write coincident with pop at level 1");
    applyStimulus(1'b1, $urandom, -1);
    applyStimulus(1'b0, '0, -1);

    $display("[TB] random traffic");
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) write_frame($urandom);
      applyStimulus(1'b0, '0, -1);
    end
    guard = 0;
    while (model_q.size() > 0 && guard < 20) begin
      applyStimulus(1'b0, '0, -1);
      guard++;
    end

    $display("[TB] reset in the middle of the left slot");
    write_frame(32'hFFFF_0000);
    write_frame(32'h5555_AAAA);
    applyStimulus(1'b0, '0, 8);
    write_frame(32'h0F0F_F0F0);
    applyStimulus(1'b0, '0, -1);
    applyStimulus(1'b0, '0, -1);

    checkOutput("no_stuck_write", pending, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
